// File: rtl/pardcore_rst_seq.sv
// pardcore_rst_seq: per-core reset sequencer in the uncore clock domain.
// Releases boot cores after power-on. Serves software ASSERT / RELEASE / PULSE
// requests one at a time, and quiesces a core's memory traffic before putting
// that core into reset.
// Optional build macro PARDCORE_RST_TIMEOUT_EN: bounds the quiesce wait to
// TIMEOUT_CYCLES, then forces reset, reports resp_err and sets timeout_flag.
module pardcore_rst_seq #(
  parameter int                   NUM_CORES      = 2,
  parameter int                   CORE_W         = 1,
  parameter int                   POR_DELAY      = 64,
  parameter logic [NUM_CORES-1:0] BOOT_MASK      = 2'b01,
  parameter int                   HOLD_CYCLES    = 16,
  parameter int                   TIMEOUT_CYCLES = 1024
) (
  input  logic                 uncoreclk,
  input  logic                 uncore_rstn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [CORE_W-1:0]    req_core,
  input  logic [1:0]           req_op,
  output logic                 resp_valid,
  output logic                 resp_err,
  output logic [NUM_CORES-1:0] corersts,
  output logic [NUM_CORES-1:0] quiesce,
  input  logic [NUM_CORES-1:0] core_idle,
  output logic                 busy,
  output logic                 timeout_flag
);

  localparam int MAX_PH  = (POR_DELAY > HOLD_CYCLES) ? POR_DELAY : HOLD_CYCLES;
  localparam int MAX_CNT = (MAX_PH > TIMEOUT_CYCLES) ? MAX_PH : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] POR_LAST  = CNT_W'(POR_DELAY - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`ifdef PARDCORE_RST_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  localparam logic [1:0] OP_ASSERT  = 2'd0;
  localparam logic [1:0] OP_RELEASE = 2'd1;
  localparam logic [1:0] OP_PULSE   = 2'd2;
  localparam logic [1:0] OP_RSVD    = 2'd3;

  typedef enum logic [2:0] {
    S_POR_WAIT = 3'd0,
    S_IDLE     = 3'd1,
    S_QUIESCE  = 3'd2,
    S_HOLD     = 3'd3,
    S_RESP     = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CORE_W-1:0]      core_q, core_d;
  logic [1:0]             op_q, op_d;
  logic                   err_q, err_d;
  logic                   timeout_q, timeout_d;
  logic [NUM_CORES-1:0]   corersts_q, corersts_d;
  logic [NUM_CORES-1:0]   quiesce_q, quiesce_d;
  logic                   req_ready_q, req_ready_d;
  logic                   resp_valid_q, resp_valid_d;
  logic                   resp_err_q, resp_err_d;
  logic                   busy_q, busy_d;

  // Decode helpers: one-hot masks for the incoming and the latched core.
  logic [NUM_CORES-1:0] mask_req, mask_cur;
  logic                 accept, bad_req, req_in_rst, cur_idle;

  assign mask_req   = NUM_CORES'(1) << req_core;
  assign mask_cur   = NUM_CORES'(1) << core_q;
  assign accept     = req_valid && req_ready_q;
  assign bad_req    = (int'(req_core) >= NUM_CORES) || (req_op == OP_RSVD);
  assign req_in_rst = |(corersts_q & mask_req);
  assign cur_idle   = |(core_idle & mask_cur);

  // State and registered outputs; reset parks every core in reset.
  always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
    if (!uncore_rstn) begin
      state_q      <= S_POR_WAIT;
      cnt_q        <= '0;
      core_q       <= '0;
      op_q         <= '0;
      err_q        <= 1'b0;
      timeout_q    <= 1'b0;
      corersts_q   <= '1;
      quiesce_q    <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_q       <= core_d;
      op_q         <= op_d;
      err_q        <= err_d;
      timeout_q    <= timeout_d;
      corersts_q   <= corersts_d;
      quiesce_q    <= quiesce_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      busy_q       <= busy_d;
    end
  end

  // Next state, phase counter and latched request.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    core_d    = core_q;
    op_d      = op_q;
    err_d     = err_q;
    timeout_d = timeout_q;
    case (state_q)
      S_POR_WAIT: begin
        if (cnt_q == POR_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_IDLE: begin
        if (accept) begin
          core_d    = req_core;
          op_d      = req_op;
          err_d     = 1'b0;
          timeout_d = 1'b0;
          cnt_d     = '0;
          if (bad_req) begin
            state_d = S_RESP;
            err_d   = 1'b1;
          end else begin
            case (req_op)
              OP_ASSERT:  state_d = req_in_rst ? S_RESP : S_QUIESCE;
              OP_PULSE:   state_d = req_in_rst ? S_HOLD : S_QUIESCE;
              default:    state_d = S_RESP;
            endcase
          end
        end
      end
      S_QUIESCE: begin
        if (cur_idle) begin
          state_d = S_HOLD;
          cnt_d   = '0;
`ifdef PARDCORE_RST_TIMEOUT_EN
        end else if (cnt_q == TO_LAST) begin
          // Core never drained: force it into reset anyway and report it.
          state_d   = S_HOLD;
          cnt_d     = '0;
          err_d     = 1'b1;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_POR_WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Output values registered on the transition; only the target core's bits move.
  always_comb begin
    corersts_d   = corersts_q;
    quiesce_d    = quiesce_q;
    req_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    resp_valid_d = (state_d == S_RESP);
    resp_err_d   = (state_d == S_RESP) && err_d;
    case (state_q)
      S_POR_WAIT: begin
        if (state_d == S_IDLE) corersts_d = corersts_q & ~BOOT_MASK;
      end
      S_IDLE: begin
        if (accept && !bad_req) begin
          if (req_op == OP_RELEASE && req_in_rst) corersts_d = corersts_q & ~mask_req;
          if ((req_op == OP_ASSERT || req_op == OP_PULSE) && !req_in_rst)
            quiesce_d = quiesce_q | mask_req;
        end
      end
      S_QUIESCE: begin
        if (state_d == S_HOLD) begin
          quiesce_d  = quiesce_q & ~mask_cur;
          corersts_d = corersts_q | mask_cur;
        end
      end
      S_HOLD: begin
        if (state_d == S_RESP && op_q == OP_PULSE) corersts_d = corersts_q & ~mask_cur;
      end
      default: ;
    endcase
  end

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_err     = resp_err_q;
  assign corersts     = corersts_q;
  assign quiesce      = quiesce_q;
  assign busy         = busy_q;
  assign timeout_flag = timeout_q;

endmodule

// File: tb/tb_pardcore_rst_seq.sv
// Self-checking bench for pardcore_rst_seq (NUM_CORES=2, CORE_W=2).
module tb_pardcore_rst_seq;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_core = 2'd0;
  logic [1:0] req_op = 2'd0;
  logic       resp_valid;
  logic       resp_err;
  logic [1:0] corersts;
  logic [1:0] quiesce;
  logic [1:0] core_idle = 2'b11;
  logic       busy;
  logic       timeout_flag;

  int checks = 0;
  int failures = 0;
  bit exp_q[$];

  pardcore_rst_seq #(
    .NUM_CORES(2), .CORE_W(2), .POR_DELAY(64), .BOOT_MASK(2'b01),
    .HOLD_CYCLES(16), .TIMEOUT_CYCLES(8)
  ) dut (
    .uncoreclk(clk), .uncore_rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_core(req_core), .req_op(req_op),
    .resp_valid(resp_valid), .resp_err(resp_err),
    .corersts(corersts), .quiesce(quiesce), .core_idle(core_idle),
    .busy(busy), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one request from a negedge; expectation pushed only if it is accepted.
  task automatic send_req(input logic [1:0] core, input logic [1:0] op, input bit exp_err);
    int  n = 0;
    bit  rdy;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    rdy = (req_ready === 1'b1);
    req_valid = 1'b1; req_core = core; req_op = op;
    @(posedge clk);
    if (rdy) exp_q.push_back(exp_err);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for a response pulse, sampling at negedges.
  task automatic await_resp(input int budget, output bit got, output logic err, output int cycles);
    got = 0; err = 1'bx; cycles = 0;
    while (cycles <= budget) begin
      if (resp_valid === 1'b1) begin got = 1; err = resp_err; break; end
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset;
    logic [1:0] exp_r;
    rstn = 1'b0; req_valid = 1'b0; core_idle = 2'b11;
    repeat (3) @(negedge clk);
    checks++;
    if (corersts !== 2'b11 || busy !== 1'b1 || req_ready !== 1'b0 || resp_valid !== 1'b0 ||
        quiesce !== 2'b00 || timeout_flag !== 1'b0) begin
      failures++;
      $display("FAIL reset_defaults: rst=%b busy=%b rdy=%b rv=%b q=%b to=%b, want 11 1 0 0 00 0",
               corersts, busy, req_ready, resp_valid, quiesce, timeout_flag);
    end
    rstn = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      exp_r = (i < 64) ? 2'b11 : 2'b10;
      checks++;
      if (corersts !== exp_r || req_ready !== (i == 64) || busy !== (i < 64)) begin
        failures++;
        $display("FAIL por_edge%0d: rst=%b rdy=%b busy=%b, want %b %b %b",
                 i, corersts, req_ready, busy, exp_r, (i == 64), (i < 64));
      end
    end
  endtask

  task automatic test_pulse_in_reset;
    bit got; logic err; int cyc; bit e;
    core_idle = 2'b11;
    send_req(2'd1, 2'd2, 1'b0);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (corersts !== 2'b10 || quiesce !== 2'b00 || resp_valid !== 1'b0) begin
        failures++;
        $display("FAIL pulse_hold%0d: rst=%b q=%b rv=%b, want 10 00 0", k, corersts, quiesce, resp_valid);
      end
      @(negedge clk);
    end
    e = exp_q.size() ? exp_q.pop_front() : 1'b1;
    checks++;
    if (resp_valid !== 1'b1 || resp_err !== e || corersts !== 2'b00) begin
      failures++;
      $display("FAIL pulse_resp: rv=%b err=%b rst=%b, want 1 %b 00", resp_valid, resp_err, corersts, e);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL pulse_ret_idle: rv=%b rdy=%b, want 0 1", resp_valid, req_ready);
    end
    await_resp(0, got, err, cyc);
  endtask

  task automatic test_assert_quiesce;
    bit got; logic err; int cyc; bit e;
    core_idle = 2'b10;
    send_req(2'd0, 2'd0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (quiesce !== 2'b01 || corersts !== 2'b00 || busy !== 1'b1) begin
        failures++;
        $display("FAIL quiesce_wait%0d: q=%b rst=%b busy=%b, want 01 00 1", k, quiesce, corersts, busy);
      end
      @(negedge clk);
    end
    core_idle = 2'b11;
    @(negedge clk);
    checks++;
    if (quiesce !== 2'b00 || corersts !== 2'b01) begin
      failures++;
      $display("FAIL quiesce_done: q=%b rst=%b, want 00 01", quiesce, corersts);
    end
    await_resp(60, got, err, cyc);
    e = exp_q.size() ? exp_q.pop_front() : 1'b1;
    checks++;
    if (!got || cyc != 16 || err !== e || corersts !== 2'b01) begin
      failures++;
      $display("FAIL assert_resp: got=%0d cyc=%0d err=%b rst=%b, want 1 16 %b 01", got, cyc, err, corersts, e);
    end
  endtask

  task automatic test_idempotent_release;
    bit got; logic err; int cyc; bit e;
    send_req(2'd0, 2'd0, 1'b0);
    await_resp(20, got, err, cyc);
    e = exp_q.size() ? exp_q.pop_front() : 1'b1;
    checks++;
    if (!got || cyc != 0 || err !== e || corersts !== 2'b01 || quiesce !== 2'b00) begin
      failures++;
      $display("FAIL assert_again: got=%0d cyc=%0d err=%b rst=%b q=%b, want 1 0 %b 01 00", got, cyc, err, corersts, quiesce, e);
    end
    send_req(2'd0, 2'd1, 1'b0);
    await_resp(20, got, err, cyc);
    e = exp_q.size() ? exp_q.pop_front() : 1'b1;
    checks++;
    if (!got || cyc != 0 || err !== e || corersts !== 2'b00) begin
      failures++;
      $display("FAIL release: got=%0d cyc=%0d err=%b rst=%b, want 1 0 %b 00", got, cyc, err, corersts, e);
    end
    send_req(2'd0, 2'd1, 1'b0);
    await_resp(20, got, err, cyc);
    e = exp_q.size() ? exp_q.pop_front() : 1'b1;
    checks++;
    if (!got || cyc != 0 || err !== e || corersts !== 2'b00) begin
      failures++;
      $display("FAIL release_again: got=%0d cyc=%0d err=%b rst=%b, want 1 0 %b 00", got, cyc, err, corersts, e);
    end
  endtask

  task automatic test_bad_req;
    bit got; logic err; int cyc; bit e;
    send_req(2'd3, 2'd0, 1'b1);
    await_resp(20, got, err, cyc);
    e = exp_q.size() ? exp_q.pop_front() : 1'b0;
    checks++;
    if (!got || err !== e || corersts !== 2'b00 || quiesce !== 2'b00) begin
      failures++;
      $display("FAIL bad_core: got=%0d err=%b rst=%b q=%b, want 1 %b 00 00", got, err, corersts, quiesce, e);
    end
    send_req(2'd0, 2'd3, 1'b1);
    await_resp(20, got, err, cyc);
    e = exp_q.size() ? exp_q.pop_front() : 1'b0;
    checks++;
    if (!got || err !== e || corersts !== 2'b00 || quiesce !== 2'b00) begin
      failures++;
      $display("FAIL rsvd_op: got=%0d err=%b rst=%b q=%b, want 1 %b 00 00", got, err, corersts, quiesce, e);
    end
  endtask

  task automatic test_back_to_back;
    int nresp = 0;
    bit got; logic err; int cyc; bit e;
    while (req_ready !== 1'b1) @(negedge clk);
    req_valid = 1'b1; req_core = 2'd1; req_op = 2'd3;
    for (int i = 0; i < 13; i++) begin
      if (resp_valid === 1'b1) begin
        nresp++;
        e = exp_q.size() ? exp_q.pop_front() : 1'b0;
        checks++;
        if (resp_err !== e) begin
          failures++;
          $display("FAIL b2b_err%0d: err=%b want %b", nresp, resp_err, e);
        end
      end
      if (i == 12) req_valid = 1'b0;
      else if (req_ready === 1'b1) exp_q.push_back(1'b1);
      @(negedge clk);
    end
    while (exp_q.size() > 0) begin
      await_resp(20, got, err, cyc);
      e = exp_q.pop_front();
      nresp++;
      checks++;
      if (!got || err !== e) begin
        failures++;
        $display("FAIL b2b_drain: got=%0d err=%b want %b", got, err, e);
      end
      @(negedge clk);
    end
    checks++;
    if (nresp != 6) begin
      failures++;
      $display("FAIL b2b_count: responses=%0d want 6", nresp);
    end
  endtask

  task automatic test_reset_mid_hold;
    bit saw_resp = 0;
    core_idle = 2'b11;
    send_req(2'd1, 2'd2, 1'b0);
    @(negedge clk);
    checks++;
    if (corersts !== 2'b10 || quiesce !== 2'b00 || busy !== 1'b1) begin
      failures++;
      $display("FAIL pulse_quiesce_fast: rst=%b q=%b busy=%b, want 10 00 1", corersts, quiesce, busy);
    end
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++;
    if (corersts !== 2'b11 || busy !== 1'b1 || req_ready !== 1'b0 || resp_valid !== 1'b0 || quiesce !== 2'b00) begin
      failures++;
      $display("FAIL midrst_async: rst=%b busy=%b rdy=%b rv=%b q=%b, want 11 1 0 0 00",
               corersts, busy, req_ready, resp_valid, quiesce);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) saw_resp = 1;
      if (i == 63 || i == 64) begin
        checks++;
        if (corersts !== ((i == 63) ? 2'b11 : 2'b10)) begin
          failures++;
          $display("FAIL midrst_por%0d: rst=%b want %b", i, corersts, (i == 63) ? 2'b11 : 2'b10);
        end
      end
    end
    checks++;
    if (saw_resp) begin
      failures++;
      $display("FAIL midrst_no_resp: resp_valid=1 seen, want never");
    end
  endtask

`ifdef PARDCORE_RST_TIMEOUT_EN
  task automatic test_timeout;
    bit got; logic err; int cyc; bit e;
    core_idle = 2'b00;
    send_req(2'd0, 2'd0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (quiesce !== 2'b01 || corersts !== 2'b10 || timeout_flag !== 1'b0) begin
        failures++;
        $display("FAIL to_wait%0d: q=%b rst=%b to=%b, want 01 10 0", k, quiesce, corersts, timeout_flag);
      end
      @(negedge clk);
    end
    checks++;
    if (quiesce !== 2'b00 || corersts !== 2'b11 || timeout_flag !== 1'b1) begin
      failures++;
      $display("FAIL to_force: q=%b rst=%b to=%b, want 00 11 1", quiesce, corersts, timeout_flag);
    end
    await_resp(40, got, err, cyc);
    e = exp_q.size() ? exp_q.pop_front() : 1'b0;
    checks++;
    if (!got || cyc != 16 || err !== e) begin
      failures++;
      $display("FAIL to_resp: got=%0d cyc=%0d err=%b, want 1 16 %b", got, cyc, err, e);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (timeout_flag !== 1'b1) begin
      failures++;
      $display("FAIL to_sticky: to=%b want 1", timeout_flag);
    end
    core_idle = 2'b11;
    send_req(2'd0, 2'd1, 1'b0);
    checks++;
    if (timeout_flag !== 1'b0 || corersts !== 2'b10) begin
      failures++;
      $display("FAIL to_clear: to=%b rst=%b, want 0 10", timeout_flag, corersts);
    end
    await_resp(20, got, err, cyc);
    e = exp_q.size() ? exp_q.pop_front() : 1'b1;
    checks++;
    if (!got || err !== e) begin
      failures++;
      $display("FAIL to_release_resp: got=%0d err=%b want 1 %b", got, err, e);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_pulse_in_reset;
    test_assert_quiesce;
    test_idempotent_release;
    test_bad_req;
    test_back_to_back;
    test_reset_mid_hold;
`ifdef PARDCORE_RST_TIMEOUT_EN
    test_timeout;
`endif
    checks++;
    if (timeout_flag !== 1'b0) begin
      failures++;
      $display("FAIL final_timeout_flag: to=%b want 0", timeout_flag);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
